// File: rtl/ex_div.sv
// ex_div: multi-cycle radix-2 restoring divider for MIPS DIV/DIVU in EX.
// Drives the EX stall request while a division is in flight and treats the
// controller's flush as an annul. result_o = {remainder, quotient}.
// Optional build macro: DIV_ZERO_FLAG_EN. When it is defined, a zero divisor
// raises div_zero_o in END and returns {dividend, all-ones}.
module ex_div #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signed_div_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic                 start_i,
    input  logic                 annul_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o,
    output logic                 stallreq_o,
    output logic                 div_zero_o
);

    typedef enum logic [1:0] {S_FREE, S_BYZERO, S_ON, S_END} state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_rem;      // partial remainder
    logic [WIDTH-1:0]   r_quo;      // dividend magnitude, shifted into quotient
    logic [WIDTH-1:0]   r_divisor;  // divisor magnitude
    logic               r_neg_q;    // quotient must be negated at the end
    logic               r_neg_r;    // remainder must be negated at the end
`ifdef DIV_ZERO_FLAG_EN
    logic [WIDTH-1:0]   r_dividend; // raw dividend for the divide-by-zero result
`endif

    logic [WIDTH:0]     w_shift;
    logic               w_ge;
    logic [WIDTH-1:0]   w_diff;
    logic [WIDTH-1:0]   w_q_fix;
    logic [WIDTH-1:0]   w_r_fix;

    // Two's-complement magnitude of an operand when dividing signed.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
        return (sgn && v[WIDTH-1]) ? (~v + 1'b1) : v;
    endfunction

    // Conditional two's-complement negation used by the sign fix-up.
    function automatic logic [WIDTH-1:0] cneg(input logic [WIDTH-1:0] v, input logic n);
        return n ? (~v + 1'b1) : v;
    endfunction

    // One restoring step: shift {rem,quo} left, trial-subtract the divisor.
    always_comb begin
        w_shift = {r_rem, r_quo[WIDTH-1]};
        w_ge    = (w_shift >= {1'b0, r_divisor});
        // The true difference is below the divisor, so the low WIDTH bits suffice.
        w_diff  = w_shift[WIDTH-1:0] - r_divisor;
        w_q_fix = cneg(r_quo, r_neg_q);
        w_r_fix = cneg(r_rem, r_neg_r);
    end

    // Stall the pipeline from acceptance until the result is ready; a flush
    // always releases it.
    assign stallreq_o = ~annul_i & (((r_state == S_FREE) & start_i) |
                                    (r_state == S_ON) | (r_state == S_BYZERO));

`ifndef DIV_ZERO_FLAG_EN
    assign div_zero_o = 1'b0;
`endif

    // Divider FSM with registered result, ready and divide-by-zero outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_FREE;
            r_cnt      <= '0;
            r_rem      <= '0;
            r_quo      <= '0;
            r_divisor  <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            result_o   <= '0;
            ready_o    <= 1'b0;
`ifdef DIV_ZERO_FLAG_EN
            r_dividend <= '0;
            div_zero_o <= 1'b0;
`endif
        end else if (annul_i) begin
            r_state    <= S_FREE;
            result_o   <= '0;
            ready_o    <= 1'b0;
`ifdef DIV_ZERO_FLAG_EN
            div_zero_o <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_FREE: begin
                    if (start_i) begin
                        if (opdata2_i == '0) begin
                            r_state <= S_BYZERO;
`ifdef DIV_ZERO_FLAG_EN
                            r_dividend <= opdata1_i;
`endif
                        end else begin
                            r_state   <= S_ON;
                            r_cnt     <= '0;
                            r_rem     <= '0;
                            r_quo     <= mag(opdata1_i, signed_div_i);
                            r_divisor <= mag(opdata2_i, signed_div_i);
                            r_neg_q   <= signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                            r_neg_r   <= signed_div_i & opdata1_i[WIDTH-1];
                        end
                    end
                end
                S_BYZERO: begin
                    r_state <= S_END;
                    ready_o <= 1'b1;
`ifdef DIV_ZERO_FLAG_EN
                    result_o   <= {r_dividend, {WIDTH{1'b1}}};
                    div_zero_o <= 1'b1;
`else
                    result_o   <= '0;
`endif
                end
                S_ON: begin
                    if (r_cnt != CNT_W'(WIDTH)) begin
                        r_rem <= w_ge ? w_diff : w_shift[WIDTH-1:0];
                        r_quo <= {r_quo[WIDTH-2:0], w_ge};
                        r_cnt <= r_cnt + 1'b1;
                    end else begin
                        r_state  <= S_END;
                        result_o <= {w_r_fix, w_q_fix};
                        ready_o  <= 1'b1;
                    end
                end
                S_END: begin
                    if (!start_i) begin
                        r_state  <= S_FREE;
                        result_o <= '0;
                        ready_o  <= 1'b0;
`ifdef DIV_ZERO_FLAG_EN
                        div_zero_o <= 1'b0;
`endif
                    end
                end
                default: r_state <= S_FREE;
            endcase
        end
    end

endmodule

// File: doc/ex_div.md
Name: ex_div

Overview:
- Multi-cycle 32-bit divider in the EX stage, radix-2 restoring, serving MIPS DIV/DIVU.
- It is the requesting end of the pipeline stall/flush protocol. While a division is in flight it drives the EX stall request into the pipeline controller.
- It consumes the controller's flush as an annul.
- Results go to the HI/LO write path: quotient to LO, remainder to HI.

Parameters:
- WIDTH, 32, operand width; result is 2*WIDTH.
- CNT_W, 6, iteration counter width; must hold the value WIDTH.

Ports:
- clk  input  1  pipeline clock
- rst  input  1  asynchronous, active-high reset
- signed_div_i  input  1  1 = DIV (signed), 0 = DIVU
- opdata1_i  input  WIDTH  dividend
- opdata2_i  input  WIDTH  divisor
- start_i  input  1  EX requests a division; held high until ready_o is seen
- annul_i  input  1  pipeline flush; aborts any operation
- result_o  output  2*WIDTH  {remainder, quotient}
- ready_o  output  1  result_o valid
- stallreq_o  output  1  EX stall request to the pipeline controller
- div_zero_o  output  1  divide-by-zero indication (see Optional Feature)

Behaviour:
- Reset (asynchronous, rst=1): state=FREE, cnt=0, result_o=0, ready_o=0, div_zero_o=0, internal dividend/divisor registers=0.
- States: FREE, BYZERO, ON, END.
- FREE:
  - start_i=1, annul_i=0, opdata2_i=0: next state BYZERO.
  - start_i=1, annul_i=0, opdata2_i≠0: next state ON; cnt=0; latch magnitudes.
  - In signed mode a negative operand is latched as its two's complement.
  - Otherwise stay in FREE.
- BYZERO: next state END; result=0.
- ON, cnt<WIDTH, one iteration per edge:
  - Shift {rem,quo} left by 1.
  - Trial-subtract the divisor from rem.
  - If the subtraction is non-negative, keep the difference and set quo[0]=1.
  - cnt++.
- ON, cnt==WIDTH: next state END. Apply sign fix-up in signed mode:
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
  - Latch result_o.
- END:
  - ready_o=1; result_o held.
  - start_i=0: next state FREE; result_o and ready_o clear to 0.
  - start_i=1: stay in END.
- annul_i=1 in any state: next state FREE; ready_o=0; result_o=0. annul_i takes priority over start_i in the same cycle.
- stallreq_o (combinational) = (FREE & start_i & ~annul_i) | ON | BYZERO, gated to 0 when annul_i=1. It is 0 in END, so the controller releases the pipeline exactly in the ready cycle.
- Latency:
  - Nonzero divisor: ready_o rises after the edge WIDTH+2 edges after the accepting edge, i.e. 34 edges for WIDTH=32.
  - Zero divisor: 2 edges.
- Signed corner 0x80000000 / 0xFFFFFFFF gives q=0x80000000, r=0 (wrap, no trap).
- Reset mid-operation aborts immediately; no partial result is visible.

Optional Feature:
- Macro: DIV_ZERO_FLAG_EN.
- Defined: div_zero_o=1 in END when the operation came via BYZERO; cleared on leaving END. result_o = {opdata1 latched, 32'hFFFFFFFF}, matching the common MIPS convention.
- Undefined: div_zero_o tied 0; a zero divisor yields result_o=0.
- Latency is identical in both builds.

Test Plan:
- Unsigned 100/7, start held: stallreq_o=1 for 34 cycles, then ready_o=1, result_o={32'd2, 32'd14}, stallreq_o=0; drop start_i → FREE, ready_o=0 next edge.
- Signed -7/2 (0xFFFFFFF9 / 0x2) → result_o={0xFFFFFFFF, 0xFFFFFFFD}. Signed 7/-2 → {0x00000001, 0xFFFFFFFD}.
- Divisor 0, dividend 0x1234 → ready after 2 edges.
  - Macro off: result_o=0, div_zero_o=0.
  - Macro on: result_o={0x1234, 0xFFFFFFFF}, div_zero_o=1.
- annul_i pulsed at iteration 10 of an ON operation → FREE next edge; stallreq_o=0, ready_o never rises. A new start afterwards completes correctly, e.g. 0xFFFFFFFF/0x10 unsigned → {0xF, 0x0FFFFFFF}.
- rst asserted asynchronously mid-ON (between edges) → ready_o=0, result_o=0, stallreq_o follows start_i/FREE immediately. 0x80000000 / 0xFFFFFFFF signed → {0, 0x80000000}.
